mmio_rd_scheduler: RTL

- Sequences host MMIO requests from the Rx side onto a single AVMM master and feeds the Tx completion bridge's tag-tracker sideband (strobe/tag/length/req_id/low_addr).
- Enforces a completion credit limit: at most MAX_INFLIGHT reads may sit between AVMM issue and Tx completion handshake. This prevents overflow of the completion response FIFO, which has no backpressure of its own.
- Also runs a read-response timeout watchdog.

---
 rtl/mmio_rd_scheduler_if.sv | 59 +++++
 rtl/mmio_rd_scheduler.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mmio_rd_scheduler_if.sv
// Request, AVMM master and tag-tracker sideband bundle for mmio_rd_scheduler.
interface mmio_rd_scheduler_if #(
    parameter int unsigned AVMM_ADDR_WIDTH = 20,
    parameter int unsigned AVMM_DATA_WIDTH = 64
);
    localparam int unsigned BE = AVMM_DATA_WIDTH / 8;

    // Host request from the Rx side
    logic                       req_valid;
    logic                       req_ready;
    logic                       req_is_wr;
    logic [AVMM_ADDR_WIDTH-1:0] req_addr;
    logic [9:0]                 req_tag;
    logic [13:0]                req_length;
    logic [15:0]                req_req_id;
    logic [AVMM_DATA_WIDTH-1:0] req_wdata;
    logic [BE-1:0]              req_byteen;

    // AVMM master
    logic [AVMM_ADDR_WIDTH-1:0] avmm_m2s_address;
    logic                       avmm_m2s_read;
    logic                       avmm_m2s_write;
    logic [AVMM_DATA_WIDTH-1:0] avmm_m2s_writedata;
    logic [BE-1:0]              avmm_m2s_byteenable;
    logic                       avmm_s2m_waitrequest;
    logic                       avmm_s2m_readdatavalid;

    // Tx completion bridge
    logic                       cpl_sent;
    logic                       tlp_rd_strb;
    logic [9:0]                 tlp_rd_tag;
    logic [13:0]                tlp_rd_length;
    logic [15:0]                tlp_rd_req_id;
    logic [23:0]                tlp_rd_low_addr;

    // Scheduler view
    modport slave (
        input  req_valid, req_is_wr, req_addr, req_tag, req_length, req_req_id,
               req_wdata, req_byteen,
        output req_ready,
        output avmm_m2s_address, avmm_m2s_read, avmm_m2s_write,
               avmm_m2s_writedata, avmm_m2s_byteenable,
        input  avmm_s2m_waitrequest, avmm_s2m_readdatavalid,
        input  cpl_sent,
        output tlp_rd_strb, tlp_rd_tag, tlp_rd_length, tlp_rd_req_id, tlp_rd_low_addr
    );

    // Environment view (request source, AVMM slave, Tx bridge)
    modport master (
        output req_valid, req_is_wr, req_addr, req_tag, req_length, req_req_id,
               req_wdata, req_byteen,
        input  req_ready,
        input  avmm_m2s_address, avmm_m2s_read, avmm_m2s_write,
               avmm_m2s_writedata, avmm_m2s_byteenable,
        output avmm_s2m_waitrequest, avmm_s2m_readdatavalid,
        output cpl_sent,
        input  tlp_rd_strb, tlp_rd_tag, tlp_rd_length, tlp_rd_req_id, tlp_rd_low_addr
    );
endinterface

// File: rtl/mmio_rd_scheduler.sv
// MMIO request sequencer: one AVMM command at a time, completion-credit
// limiting for reads, tag-tracker sideband strobe and read-response watchdog.
module mmio_rd_scheduler #(
    parameter int unsigned AVMM_ADDR_WIDTH = 20,
    parameter int unsigned AVMM_DATA_WIDTH = 64,
    parameter int unsigned MAX_INFLIGHT    = 16,
    parameter int unsigned TIMEOUT_CYCLES  = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    mmio_rd_scheduler_if.slave   bus,
    output logic [7:0]           inflight_cnt,
    output logic                 err_unsupported,
    output logic                 err_underflow,
    output logic                 err_rd_timeout
);
    localparam int unsigned BE   = AVMM_DATA_WIDTH / 8;
    localparam int unsigned WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0]            WD_MAX    = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]                 CNT_MAX   = 8'(MAX_INFLIGHT);
    localparam logic [13:0]                LEN_MAX   = 14'(BE);
    localparam logic [AVMM_ADDR_WIDTH-1:0] ADDR_MASK = ~AVMM_ADDR_WIDTH'(7);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_ISSUE = 2'd1,
        WR_ISSUE = 2'd2
    } state_e;

    state_e                     state_q, state_d;
    logic [AVMM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [23:0]                low_addr_q, low_addr_d;
    logic [9:0]                 tag_q, tag_d;
    logic [13:0]                len_q, len_d;
    logic [15:0]                req_id_q, req_id_d;
    logic [AVMM_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [BE-1:0]              be_q, be_d;
    logic                       read_q, read_d;
    logic                       write_q, write_d;
    logic [7:0]                 inflight_q, inflight_d;
    logic [7:0]                 outstanding_q, outstanding_d;
    logic [WD_W-1:0]            wd_q, wd_d;
    logic                       err_unsup_q, err_unsup_d;
    logic                       err_under_q, err_under_d;
    logic                       err_to_q, err_to_d;
    logic                       req_ready_c;
    logic                       rd_accept_c;

    // Next-state, request capture, counters and watchdog
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        low_addr_d    = low_addr_q;
        tag_d         = tag_q;
        len_d         = len_q;
        req_id_d      = req_id_q;
        wdata_d       = wdata_q;
        be_d          = be_q;
        read_d        = read_q;
        write_d       = write_q;
        inflight_d    = inflight_q;
        outstanding_d = outstanding_q;
        wd_d          = wd_q;
        err_unsup_d   = err_unsup_q;
        err_under_d   = err_under_q;
        err_to_d      = err_to_q;
        req_ready_c   = 1'b0;
        rd_accept_c   = 1'b0;

        case (state_q)
            IDLE: begin
                // Writes are posted and never consume a completion credit
                req_ready_c = bus.req_is_wr ? 1'b1 : (inflight_q < CNT_MAX);
                if (bus.req_valid && req_ready_c) begin
                    addr_d     = bus.req_addr & ADDR_MASK;
                    low_addr_d = 24'(bus.req_addr);
                    tag_d      = bus.req_tag;
                    len_d      = bus.req_length;
                    req_id_d   = bus.req_req_id;
                    wdata_d    = bus.req_wdata;
                    if (bus.req_is_wr) begin
                        be_d    = bus.req_byteen;
                        write_d = 1'b1;
                        state_d = WR_ISSUE;
                    end else if (bus.req_length > LEN_MAX || bus.req_length == 14'd0) begin
                        be_d        = '1;
                        err_unsup_d = 1'b1;
                    end else begin
                        be_d    = '1;
                        read_d  = 1'b1;
                        state_d = RD_ISSUE;
                    end
                end
            end
            RD_ISSUE: begin
                if (!bus.avmm_s2m_waitrequest) begin
                    rd_accept_c = 1'b1;
                    read_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            WR_ISSUE: begin
                if (!bus.avmm_s2m_waitrequest) begin
                    write_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                read_d  = 1'b0;
                write_d = 1'b0;
                state_d = IDLE;
            end
        endcase

        // Completion credits: issued-but-not-completed reads
        if (bus.cpl_sent && inflight_q == 8'd0) begin
            err_under_d = 1'b1;
        end
        if (rd_accept_c && !bus.cpl_sent) begin
            inflight_d = inflight_q + 8'd1;
        end else if (!rd_accept_c && bus.cpl_sent && inflight_q != 8'd0) begin
            inflight_d = inflight_q - 8'd1;
        end

        // Reads still waiting for readdatavalid
        if (rd_accept_c && !bus.avmm_s2m_readdatavalid) begin
            if (outstanding_q != 8'hFF) begin
                outstanding_d = outstanding_q + 8'd1;
            end
        end else if (!rd_accept_c && bus.avmm_s2m_readdatavalid) begin
            if (outstanding_q != 8'd0) begin
                outstanding_d = outstanding_q - 8'd1;
            end
        end

        // Watchdog counts idle response cycles and parks at its limit
        if (outstanding_q == 8'd0 || bus.avmm_s2m_readdatavalid) begin
            wd_d = '0;
        end else if (wd_q != WD_MAX) begin
            wd_d = wd_q + WD_W'(1);
        end
        if (wd_d == WD_MAX) begin
            err_to_d = 1'b1;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            low_addr_q    <= '0;
            tag_q         <= '0;
            len_q         <= '0;
            req_id_q      <= '0;
            wdata_q       <= '0;
            be_q          <= '1;
            read_q        <= 1'b0;
            write_q       <= 1'b0;
            inflight_q    <= '0;
            outstanding_q <= '0;
            wd_q          <= '0;
            err_unsup_q   <= 1'b0;
            err_under_q   <= 1'b0;
            err_to_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            low_addr_q    <= low_addr_d;
            tag_q         <= tag_d;
            len_q         <= len_d;
            req_id_q      <= req_id_d;
            wdata_q       <= wdata_d;
            be_q          <= be_d;
            read_q        <= read_d;
            write_q       <= write_d;
            inflight_q    <= inflight_d;
            outstanding_q <= outstanding_d;
            wd_q          <= wd_d;
            err_unsup_q   <= err_unsup_d;
            err_under_q   <= err_under_d;
            err_to_q      <= err_to_d;
        end
    end

    // Strobe coincides with the AVMM read accept so the tag tracker sees it first
    assign bus.req_ready           = req_ready_c;
    assign bus.tlp_rd_strb         = rd_accept_c;
    assign bus.avmm_m2s_address    = addr_q;
    assign bus.avmm_m2s_read       = read_q;
    assign bus.avmm_m2s_write      = write_q;
    assign bus.avmm_m2s_writedata  = wdata_q;
    assign bus.avmm_m2s_byteenable = be_q;
    assign bus.tlp_rd_tag          = tag_q;
    assign bus.tlp_rd_length       = len_q;
    assign bus.tlp_rd_req_id       = req_id_q;
    assign bus.tlp_rd_low_addr     = low_addr_q;
    assign inflight_cnt            = inflight_q;
    assign err_unsupported         = err_unsup_q;
    assign err_underflow           = err_under_q;
    assign err_rd_timeout          = err_to_q;
endmodule
